// File: rtl/uart_receiver_if.sv
// uart_receiver_if
//   Received-byte bus from the UART RX stage to its consumer.
//   o_data        : last correctly received byte, held between frames
//   o_data_valid  : one-cycle pulse, o_data updated this cycle
//   o_frame_error : one-cycle pulse, stop bit sampled low
//   o_busy        : high while a frame is in progress
//   master = receiver (drives), slave = consumer (observes)
interface uart_receiver_if;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       o_frame_error;
  logic       o_busy;

  modport master (
    output o_data,
    output o_data_valid,
    output o_frame_error,
    output o_busy
  );

  modport slave (
    input o_data,
    input o_data_valid,
    input o_frame_error,
    input o_busy
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver
//   8N1 UART receive stage. The serial line is synchronised, the start
//   bit is confirmed at mid-bit, and every following bit is sampled one
//   bit time later, i.e. near the middle of each bit.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     i_rx  : serial line, asynchronous to clk, idle high
//     rx_o  : received-byte bus (uart_receiver_if.master)
//   Legal parameter range: 4 <= CLOCK_FREQ/BAUD_RATE <= 65535.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   IDLE      | line idle, waiting for rx_s low
//   START     | timing half a bit to confirm the start bit
//   DATA      | sampling 8 data bits, LSB first
//   STOP      | sampling the stop bit
//   WAIT_IDLE | after a framing error, wait for the line high
module uart_receiver #(
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned CLOCK_FREQ = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_rx,
  uart_receiver_if.master  rx_o
);

  localparam int unsigned BIT_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT = BIT_TIME / 2;
  localparam logic [15:0] BIT_LAST  = 16'(BIT_TIME - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  logic [1:0]  sync_q;
  logic        rx_s;
  state_t      state_q;
  logic [15:0] clk_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        data_valid_q;
  logic        frame_err_q;
  logic        busy_q;

  // Two-flop synchroniser, reset to the idle (high) line level so a
  // released reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], i_rx};
    end
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      clk_cnt_q    <= 16'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      data_q       <= 8'h00;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q   <= START;
            clk_cnt_q <= 16'd0;
            busy_q    <= 1'b1;
          end
        end

        START: begin
          if (clk_cnt_q == HALF_LAST) begin
            clk_cnt_q <= 16'd0;
            if (rx_s) begin
              // Line went back high before mid-bit: treat as a glitch.
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= DATA;
              bit_idx_q <= 3'd0;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end

        DATA: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q          <= 16'd0;
            shift_q[bit_idx_q] <= rx_s;
            if (bit_idx_q == 3'd7) begin
              state_q   <= STOP;
              bit_idx_q <= 3'd0;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end

        STOP: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= 16'd0;
            if (rx_s) begin
              // Returning to IDLE here lets the next start bit follow
              // immediately with no idle gap.
              data_q       <= shift_q;
              data_valid_q <= 1'b1;
              state_q      <= IDLE;
              busy_q       <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end

        WAIT_IDLE: begin
          // A held-low line (break) must not decode as a stream of 0x00.
          if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q   <= IDLE;
          clk_cnt_q <= 16'd0;
          bit_idx_q <= 3'd0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign rx_o.o_data        = data_q;
  assign rx_o.o_data_valid  = data_valid_q;
  assign rx_o.o_frame_error = frame_err_q;
  assign rx_o.o_busy        = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
//   Directed bench for uart_receiver with BIT_TIME=16, HALF_BIT=8.
//   A small bit-banging task plays the role of the team transmitter.
module tb_uart_receiver;

  localparam int BT = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic i_rx  = 1'b1;

  uart_receiver_if rx_if ();

  uart_receiver #(
    .BAUD_RATE  (10),
    .CLOCK_FREQ (160)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_rx  (i_rx),
    .rx_o  (rx_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int         n_valid   = 0;
  int         n_ferr    = 0;
  bit         both_seen = 1'b0;
  logic [7:0] rxq[$];
  int         tq[$];

  always @(negedge clk) begin
    if (rx_if.o_data_valid) begin
      n_valid++;
      rxq.push_back(rx_if.o_data);
      tq.push_back(cyc);
    end
    if (rx_if.o_frame_error) n_ferr++;
    if (rx_if.o_data_valid && rx_if.o_frame_error) both_seen = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_rx(input string nm, input logic [7:0] exp, output int t);
    n_cmp++;
    t = -1;
    if (rxq.size() == 0) begin
      n_bad++;
      $display("FAIL %s: got no byte expected %0h", nm, exp);
    end else begin
      logic [7:0] got;
      got = rxq.pop_front();
      t   = tq.pop_front();
      if (got !== exp) begin
        n_bad++;
        $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
    end
  endtask

  // Called at a negedge; returns at a negedge with the line left at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            output int t_start, output logic mid_busy);
    i_rx    = 1'b0;
    t_start = cyc;
    repeat (BT) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      i_rx = d[b];
      if (b == 4) begin
        repeat (BT/2) @(negedge clk);
        mid_busy = rx_if.o_busy;
        repeat (BT/2) @(negedge clk);
      end else begin
        repeat (BT) @(negedge clk);
      end
    end
    i_rx = stop;
    repeat (BT) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int         ts, tv, t0, t1, nv0, nf0;
    logic       mb;
    logic [7:0] d77;

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
    vecs[2] = '{8'h5A, 1'b0, 0, 1, 8'h3C};
    vecs[3] = '{8'h81, 1'b1, 1, 0, 8'h81};
    vecs[4] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[5] = '{8'hFF, 1'b1, 1, 0, 8'hFF};

    repeat (3) @(negedge clk);
    chk("reset o_data", rx_if.o_data, 8'h00);
    chk("reset o_data_valid", rx_if.o_data_valid, 1'b0);
    chk("reset o_frame_error", rx_if.o_frame_error, 1'b0);
    chk("reset o_busy", rx_if.o_busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Table-driven single frames with an idle gap after each.
    for (int i = 0; i < 6; i++) begin
      nv0 = n_valid;
      nf0 = n_ferr;
      send_frame(vecs[i].d, vecs[i].stop, ts, mb);
      i_rx = 1'b1;
      repeat (20) @(negedge clk);
      chk($sformatf("vec%0d valid count", i), n_valid - nv0, vecs[i].exp_valid);
      chk($sformatf("vec%0d ferr count", i), n_ferr - nf0, vecs[i].exp_ferr);
      chk($sformatf("vec%0d o_data", i), rx_if.o_data, vecs[i].exp_data);
      chk($sformatf("vec%0d busy mid-frame", i), mb, 1'b1);
      chk($sformatf("vec%0d busy after", i), rx_if.o_busy, 1'b0);
      if (vecs[i].exp_valid == 1) begin
        expect_rx($sformatf("vec%0d rx byte", i), vecs[i].exp_data, tv);
        if (i == 0) begin
          n_cmp++;
          if (tv - ts < 154 || tv - ts > 156) begin
            n_bad++;
            $display("FAIL latency: got %0d cycles expected 155 +/-1", tv - ts);
          end
        end
      end
    end

    // Glitch: 4 low cycles must not start a frame.
    nv0 = n_valid;
    nf0 = n_ferr;
    i_rx = 1'b0;
    repeat (4) @(negedge clk);
    i_rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch busy cleared", rx_if.o_busy, 1'b0);
    repeat (10) @(negedge clk);
    chk("glitch valid count", n_valid - nv0, 0);
    chk("glitch ferr count", n_ferr - nf0, 0);
    send_frame(8'h3C, 1'b1, ts, mb);
    repeat (10) @(negedge clk);
    expect_rx("after glitch 3C", 8'h3C, tv);

    // Framing error followed by a break held low for 50 cycles.
    nv0 = n_valid;
    nf0 = n_ferr;
    send_frame(8'h5A, 1'b0, ts, mb);
    repeat (50) @(negedge clk);
    chk("break ferr count", n_ferr - nf0, 1);
    chk("break valid count", n_valid - nv0, 0);
    chk("break o_data held", rx_if.o_data, 8'h3C);
    chk("break busy held", rx_if.o_busy, 1'b1);
    i_rx = 1'b1;
    repeat (6) @(negedge clk);
    chk("break busy released", rx_if.o_busy, 1'b0);
    chk("break no extra ferr", n_ferr - nf0, 1);
    send_frame(8'h81, 1'b1, ts, mb);
    repeat (10) @(negedge clk);
    expect_rx("after break 81", 8'h81, tv);

    // Back-to-back loopback stream, zero idle gap.
    nf0 = n_ferr;
    send_frame(8'h00, 1'b1, ts, mb);
    send_frame(8'h55, 1'b1, ts, mb);
    send_frame(8'hAA, 1'b1, ts, mb);
    send_frame(8'hFF, 1'b1, ts, mb);
    repeat (10) @(negedge clk);
    expect_rx("b2b 00", 8'h00, t0);
    expect_rx("b2b 55", 8'h55, t1);
    chk("b2b spacing 1", t1 - t0, 160);
    expect_rx("b2b AA", 8'hAA, t0);
    chk("b2b spacing 2", t0 - t1, 160);
    expect_rx("b2b FF", 8'hFF, t1);
    chk("b2b spacing 3", t1 - t0, 160);
    chk("b2b ferr count", n_ferr - nf0, 0);

    // Reset in the middle of bit 4 of a 0x77 frame.
    nv0 = n_valid;
    nf0 = n_ferr;
    d77 = 8'h77;
    i_rx = 1'b0;
    repeat (BT) @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      i_rx = d77[b];
      repeat (BT) @(negedge clk);
    end
    i_rx = d77[4];
    repeat (BT/2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset o_data", rx_if.o_data, 8'h00);
    chk("midreset o_busy", rx_if.o_busy, 1'b0);
    chk("midreset o_data_valid", rx_if.o_data_valid, 1'b0);
    chk("midreset o_frame_error", rx_if.o_frame_error, 1'b0);
    i_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("midreset valid count", n_valid - nv0, 0);
    chk("midreset ferr count", n_ferr - nf0, 0);
    chk("midreset busy after", rx_if.o_busy, 1'b0);
    send_frame(8'hC3, 1'b1, ts, mb);
    repeat (10) @(negedge clk);
    expect_rx("after reset C3", 8'hC3, tv);
    chk("after reset o_data", rx_if.o_data, 8'hC3);

    chk("valid and ferr exclusive", both_seen, 1'b0);
    chk("no stray bytes", rxq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
